regfile_wb_arbiter: RTL

REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

---
 rtl/regfile_wb_arbiter.sv | 127 ++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file scoreboard with a round-robin writeback arbiter for two producers.
// Tracks pending writes, stalls hazardous issues and drives a single register-file write port.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic [ADDR_W-1:0] issue_rs1_add,
   input  logic [ADDR_W-1:0] issue_rs2_add,
   input  logic [ADDR_W-1:0] issue_rd_add,
   output logic              issue_stall,
   input  logic              a_valid,
   input  logic [ADDR_W-1:0] a_rd_add,
   input  logic [DATA_W-1:0] a_data,
   output logic              a_ready,
   input  logic              b_valid,
   input  logic [ADDR_W-1:0] b_rd_add,
   input  logic [DATA_W-1:0] b_data,
   output logic              b_ready,
   output logic              reg_write,
   output logic [ADDR_W-1:0] rd_add,
   output logic [DATA_W-1:0] write_reg_data,
   output logic [ADDR_W:0]   busy_count,
   output logic              wb_err
);

   localparam int NREG = 1 << ADDR_W;

   typedef enum logic {
      GNT_A = 1'b0,
      GNT_B = 1'b1
   } grant_e;

   logic [NREG-1:0]   busy_q, busy_d;
   logic [ADDR_W:0]   count_q, count_d;
   grant_e            last_q, last_d;
   logic              err_q, err_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] data_q, data_d;

   logic              issue_accept;
   logic              grant_a, grant_b, xfer;
   logic [ADDR_W-1:0] xfer_rd;
   logic [DATA_W-1:0] xfer_data;
   logic              xfer_wr;

   // Hazard check uses registered busy bits only; a clear on this edge is not bypassed.
   assign issue_stall  = issue_valid &
                         (busy_q[issue_rs1_add] | busy_q[issue_rs2_add] | busy_q[issue_rd_add]);
   assign issue_accept = issue_valid & ~issue_stall;

   // Lone requester wins; under contention the one not granted last wins.
   assign grant_a   = a_valid & (~b_valid | (last_q == GNT_B));
   assign grant_b   = b_valid & (~a_valid | (last_q == GNT_A));
   assign a_ready   = grant_a;
   assign b_ready   = grant_b;
   assign xfer      = grant_a | grant_b;
   assign xfer_rd   = grant_a ? a_rd_add : b_rd_add;
   assign xfer_data = grant_a ? a_data : b_data;
   assign xfer_wr   = xfer & (xfer_rd != '0);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
      busy_d  = busy_q;
      last_d  = last_q;
      err_d   = err_q;
      we_d    = xfer_wr;
      rd_d    = rd_q;
      data_d  = data_q;
      count_d = '0;

      if (xfer) begin
         last_d = grant_a ? GNT_A : GNT_B;
      end

      if (xfer_wr) begin
         rd_d   = xfer_rd;
         data_d = xfer_data;
         if (!busy_q[xfer_rd]) begin
            err_d = 1'b1;
         end
         busy_d[xfer_rd] = 1'b0;
      end

      // Applied after the clear so a same-edge issue to the same register keeps it busy.
      if (issue_accept) begin
         busy_d[issue_rd_add] = 1'b1;
      end
      busy_d[0] = 1'b0;

      for (int i = 0; i < NREG; i++) begin
         count_d = count_d + (ADDR_W + 1)'(busy_d[i]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments; the async reset clears
   // every register, including the in-flight write, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q  <= '0;
         count_q <= '0;
         last_q  <= GNT_B;
         err_q   <= 1'b0;
         we_q    <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         busy_q  <= busy_d;
         count_q <= count_d;
         last_q  <= last_d;
         err_q   <= err_d;
         we_q    <= we_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign reg_write      = we_q;
   assign rd_add         = rd_q;
   assign write_reg_data = data_q;
   assign busy_count     = count_q;
   assign wb_err         = err_q;

endmodule
